// File: rtl/ring_phase_monitor_if.sv
// Bundle between the 3-bit one-hot ring counter and its phase monitor.
// The monitor sits on the slave modport; the ring/sequencer side uses master.
interface ring_phase_monitor_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr_cnt;
    logic [2:0]       ring_q;
    logic [1:0]       phase;
    logic             valid;
    logic             rot_tick;
    logic [CNT_W-1:0] rot_cnt;
    logic             seq_err;
    logic [7:0]       err_cnt;
    logic             resync_req;

    modport master (
        output en, clr_cnt, ring_q,
        input  phase, valid, rot_tick, rot_cnt, seq_err, err_cnt, resync_req
    );

    modport slave (
        input  en, clr_cnt, ring_q,
        output phase, valid, rot_tick, rot_cnt, seq_err, err_cnt, resync_req
    );
endinterface

// File: rtl/ring_phase_monitor.sv
// One-hot ring phase checker: decodes phase, counts rotations and faults, requests resync.
// All outputs registered, 1-cycle latency; no backpressure, en=0 freezes everything.
module ring_phase_monitor #(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ring_phase_monitor_if.slave   mon
);
    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    localparam logic [3:0] LIMIT = ERR_LIMIT[3:0];

    state_t           state_q,    state_d;
    logic [2:0]       prev_q,     prev_d;
    logic [3:0]       consec_q,   consec_d;
    logic [1:0]       phase_q,    phase_d;
    logic             valid_q,    valid_d;
    logic             rot_tick_q, rot_tick_d;
    logic [CNT_W-1:0] rot_cnt_q,  rot_cnt_d;
    logic             seq_err_q,  seq_err_d;
    logic [7:0]       err_cnt_q,  err_cnt_d;
    logic             resync_q,   resync_d;

    logic       legal;
    logic [2:0] succ;
    logic [1:0] dec_phase;

    assign legal = (mon.ring_q == 3'b100) || (mon.ring_q == 3'b010) || (mon.ring_q == 3'b001);
    // Ring rotates the hot bit right: 100 -> 010 -> 001 -> 100.
    assign succ  = {prev_q[0], prev_q[2:1]};

    always_comb begin
        dec_phase = 2'd3;
        case (mon.ring_q)
            3'b100:  dec_phase = 2'd0;
            3'b010:  dec_phase = 2'd1;
            3'b001:  dec_phase = 2'd2;
            default: dec_phase = 2'd3;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        consec_d   = consec_q;
        phase_d    = phase_q;
        valid_d    = valid_q;
        rot_tick_d = 1'b0;
        rot_cnt_d  = rot_cnt_q;
        seq_err_d  = 1'b0;
        err_cnt_d  = err_cnt_q;
        resync_d   = resync_q;

        if (mon.en) begin
            phase_d = dec_phase;
            case (state_q)
                IDLE: begin
                    if (legal) begin
                        prev_d  = mon.ring_q;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (legal && (mon.ring_q == succ)) begin
                        prev_d   = mon.ring_q;
                        consec_d = 4'd0;
                        if (prev_q == 3'b001) begin
                            rot_tick_d = 1'b1;
                            rot_cnt_d  = rot_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        consec_d = consec_q + 4'd1;
                        if (legal) begin
                            prev_d = mon.ring_q;
                        end
                        if (consec_d >= LIMIT) begin
                            state_d = FAULT;
                        end
                    end
                end
                FAULT: begin
                    if (mon.ring_q == 3'b100) begin
                        prev_d   = 3'b100;
                        consec_d = 4'd0;
                        state_d  = TRACK;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Clear wins over the count update but leaves the event pulses intact.
            if (mon.clr_cnt) begin
                rot_cnt_d = '0;
                err_cnt_d = 8'd0;
            end

            valid_d  = legal && (state_d == TRACK);
            resync_d = (state_d == FAULT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= 3'b000;
            consec_q   <= 4'd0;
            phase_q    <= 2'd3;
            valid_q    <= 1'b0;
            rot_tick_q <= 1'b0;
            rot_cnt_q  <= '0;
            seq_err_q  <= 1'b0;
            err_cnt_q  <= 8'd0;
            resync_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            consec_q   <= consec_d;
            phase_q    <= phase_d;
            valid_q    <= valid_d;
            rot_tick_q <= rot_tick_d;
            rot_cnt_q  <= rot_cnt_d;
            seq_err_q  <= seq_err_d;
            err_cnt_q  <= err_cnt_d;
            resync_q   <= resync_d;
        end
    end

    assign mon.phase      = phase_q;
    assign mon.valid      = valid_q;
    assign mon.rot_tick   = rot_tick_q;
    assign mon.rot_cnt    = rot_cnt_q;
    assign mon.seq_err    = seq_err_q;
    assign mon.err_cnt    = err_cnt_q;
    assign mon.resync_req = resync_q;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor: one instance with ERR_LIMIT=2, one with ERR_LIMIT=15.
module tb_ring_phase_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   total  = 0;
    logic [2:0] r;

    always #5 clk = ~clk;

    ring_phase_monitor_if #(.CNT_W(8)) bus2 ();
    ring_phase_monitor_if #(.CNT_W(8)) bus15 ();

    ring_phase_monitor #(.CNT_W(8), .ERR_LIMIT(2))  u_dut2  (.clk(clk), .rst(rst), .mon(bus2));
    ring_phase_monitor #(.CNT_W(8), .ERR_LIMIT(15)) u_dut15 (.clk(clk), .rst(rst), .mon(bus15));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step2(input logic [2:0] ring, input logic e, input logic c);
        @(negedge clk);
        bus2.ring_q  = ring;
        bus2.en      = e;
        bus2.clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step15(input logic [2:0] ring, input logic e, input logic c);
        @(negedge clk);
        bus15.ring_q  = ring;
        bus15.en      = e;
        bus15.clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic exp2(input string tag, input logic [1:0] ph, input logic vl, input logic tk,
                        input logic [7:0] rc, input logic se, input logic [7:0] ec, input logic rs);
        chk({tag, ".phase"},    32'(bus2.phase),      32'(ph));
        chk({tag, ".valid"},    32'(bus2.valid),      32'(vl));
        chk({tag, ".rot_tick"}, 32'(bus2.rot_tick),   32'(tk));
        chk({tag, ".rot_cnt"},  32'(bus2.rot_cnt),    32'(rc));
        chk({tag, ".seq_err"},  32'(bus2.seq_err),    32'(se));
        chk({tag, ".err_cnt"},  32'(bus2.err_cnt),    32'(ec));
        chk({tag, ".resync"},   32'(bus2.resync_req), 32'(rs));
    endtask

    task automatic exp15(input string tag, input logic [1:0] ph, input logic vl, input logic tk,
                         input logic [7:0] rc, input logic se, input logic [7:0] ec, input logic rs);
        chk({tag, ".phase"},    32'(bus15.phase),      32'(ph));
        chk({tag, ".valid"},    32'(bus15.valid),      32'(vl));
        chk({tag, ".rot_tick"}, 32'(bus15.rot_tick),   32'(tk));
        chk({tag, ".rot_cnt"},  32'(bus15.rot_cnt),    32'(rc));
        chk({tag, ".seq_err"},  32'(bus15.seq_err),    32'(se));
        chk({tag, ".err_cnt"},  32'(bus15.err_cnt),    32'(ec));
        chk({tag, ".resync"},   32'(bus15.resync_req), 32'(rs));
    endtask

    initial begin
        bus2.en = 1'b0;  bus2.clr_cnt = 1'b0;  bus2.ring_q = 3'b000;
        bus15.en = 1'b0; bus15.clr_cnt = 1'b0; bus15.ring_q = 3'b000;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        exp2("rst2", 2'd3, 0, 0, 8'd0, 0, 8'd0, 0);
        exp15("rst15", 2'd3, 0, 0, 8'd0, 0, 8'd0, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: clean rotations
        for (int i = 0; i < 13; i++) begin
            r = (i % 3 == 0) ? 3'b100 : ((i % 3 == 1) ? 3'b010 : 3'b001);
            step2(r, 1, 0);
            exp2($sformatf("t1_s%0d", i), 2'(i % 3), 1, (i > 0) && (i % 3 == 0),
                 8'(i / 3), 0, 8'd0, 0);
        end

        // 2: illegal sample then recovery, no fault
        step2(3'b010, 1, 0); exp2("t2_010", 2'd1, 1, 0, 8'd4, 0, 8'd0, 0);
        step2(3'b011, 1, 0); exp2("t2_011", 2'd3, 0, 0, 8'd4, 1, 8'd1, 0);
        step2(3'b001, 1, 0); exp2("t2_001", 2'd2, 1, 0, 8'd4, 0, 8'd1, 0);

        // 3: two bad samples -> FAULT, resync on 100 only
        step2(3'b000, 1, 0); exp2("t3_000", 2'd3, 0, 0, 8'd4, 1, 8'd2, 0);
        step2(3'b111, 1, 0); exp2("t3_111", 2'd3, 0, 0, 8'd4, 1, 8'd3, 1);
        step2(3'b010, 1, 0); exp2("t3_010", 2'd1, 0, 0, 8'd4, 0, 8'd3, 1);
        step2(3'b100, 1, 0); exp2("t3_100", 2'd0, 1, 0, 8'd4, 0, 8'd3, 0);

        // 4: out-of-order 001 then 100 still rotates
        step2(3'b001, 1, 0); exp2("t4_001", 2'd2, 1, 0, 8'd4, 1, 8'd4, 0);
        step2(3'b100, 1, 0); exp2("t4_100", 2'd0, 1, 1, 8'd5, 0, 8'd4, 0);

        // 5: en=0 freeze, then clear coincident with wrap and with a bad sample
        step2(3'b011, 0, 0); exp2("t5_h0", 2'd0, 1, 0, 8'd5, 0, 8'd4, 0);
        step2(3'b111, 0, 1); exp2("t5_h1", 2'd0, 1, 0, 8'd5, 0, 8'd4, 0);
        step2(3'b000, 0, 0); exp2("t5_h2", 2'd0, 1, 0, 8'd5, 0, 8'd4, 0);
        step2(3'b110, 0, 0); exp2("t5_h3", 2'd0, 1, 0, 8'd5, 0, 8'd4, 0);
        step2(3'b101, 0, 0); exp2("t5_h4", 2'd0, 1, 0, 8'd5, 0, 8'd4, 0);
        step2(3'b010, 1, 0); exp2("t5_010", 2'd1, 1, 0, 8'd5, 0, 8'd4, 0);
        step2(3'b001, 1, 0); exp2("t5_001", 2'd2, 1, 0, 8'd5, 0, 8'd4, 0);
        step2(3'b100, 1, 1); exp2("t5_clrwrap", 2'd0, 1, 1, 8'd0, 0, 8'd0, 0);
        step2(3'b100, 1, 1); exp2("t5_clrbad", 2'd0, 1, 0, 8'd0, 1, 8'd0, 0);
        step2(3'b010, 1, 0); exp2("t5_010b", 2'd1, 1, 0, 8'd0, 0, 8'd0, 0);
        bus2.en = 1'b0;

        // 6: err_cnt saturation on the ERR_LIMIT=15 instance
        step15(3'b100, 1, 0); exp15("t6_start", 2'd0, 1, 0, 8'd0, 0, 8'd0, 0);
        for (int b = 0; b < 18; b++) begin
            for (int k = 0; k < 15; k++) begin
                step15(3'b000, 1, 0);
                total++;
                if (k == 13) chk($sformatf("t6_b%0d_nofault", b), 32'(bus15.resync_req), 32'd0);
            end
            exp15($sformatf("t6_b%0d", b), 2'd3, 0, 0, 8'd0, 1,
                  8'((total > 255) ? 255 : total), 1);
            if (b < 17) begin
                step15(3'b100, 1, 0);
                exp15($sformatf("t6_r%0d", b), 2'd0, 1, 0, 8'd0, 0,
                      8'((total > 255) ? 255 : total), 0);
            end
        end
        chk("t6_sat", 32'(bus15.err_cnt), 32'd255);

        // Reset while in FAULT
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp15("t6_rst15", 2'd3, 0, 0, 8'd0, 0, 8'd0, 0);
        exp2("t6_rst2", 2'd3, 0, 0, 8'd0, 0, 8'd0, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
